cpu_mem_responder: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 16 +
 rtl/cpu_mem_responder_mmio_regs.sv | 67 ++++++
 rtl/cpu_mem_responder.sv | 92 +++++++++
 tb/tb_cpu_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU bus memory responder.
//   MMIO_BASE_DEF : default first word address of the register bank
//   OFS_*         : word offsets of the registers inside the bank
//   ID_CONST      : value returned by the read-only ID register
package cpu_bus_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hFFF0;

  localparam logic [3:0] OFS_GPIO  = 4'd0;
  localparam logic [3:0] OFS_CYC   = 4'd1;
  localparam logic [3:0] OFS_WCNT  = 4'd2;
  localparam logic [3:0] OFS_IDREG = 4'd3;

  localparam logic [15:0] ID_CONST = 16'hC0DE;

endpackage

// File: rtl/cpu_mem_responder_mmio_regs.sv
// Memory-mapped register bank: GPIO output, free-running cycle counter and
// accepted-write counter, plus a combinational read mux by word offset.
// Ports:
//   CK       : clock, rising edge
//   RST      : synchronous reset, active-low
//   i_we     : write strobe for the register addressed by i_ofs
//   i_ofs    : word offset inside the bank (0..15)
//   i_wdata  : write data
//   i_cnt    : an accepted bus write happened this cycle (any target)
//   o_rdata  : read data for i_ofs
//   o_gpio   : GPIO output register
module mmio_regs
  import cpu_bus_pkg::*;
(
  input  logic        CK,
  input  logic        RST,
  input  logic        i_we,
  input  logic [3:0]  i_ofs,
  input  logic [15:0] i_wdata,
  input  logic        i_cnt,
  output logic [15:0] o_rdata,
  output logic [15:0] o_gpio
);

  logic [15:0] r_gpio;
  logic [15:0] r_cyc;
  logic [15:0] r_wcnt;

  // A write to a counter takes priority over its own increment on that edge.
  always_ff @(posedge CK) begin
    if (!RST) begin
      r_gpio <= 16'h0000;
      r_cyc  <= 16'h0000;
      r_wcnt <= 16'h0000;
    end else begin
      if (i_we && (i_ofs == OFS_GPIO)) begin
        r_gpio <= i_wdata;
      end

      if (i_we && (i_ofs == OFS_CYC)) begin
        r_cyc <= i_wdata;
      end else begin
        r_cyc <= r_cyc + 16'd1;
      end

      if (i_we && (i_ofs == OFS_WCNT)) begin
        r_wcnt <= i_wdata;
      end else if (i_cnt) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
    end
  end

  always_comb begin
    o_rdata = 16'h0000;
    case (i_ofs)
      OFS_GPIO:  o_rdata = r_gpio;
      OFS_CYC:   o_rdata = r_cyc;
      OFS_WCNT:  o_rdata = r_wcnt;
      OFS_IDREG: o_rdata = ID_CONST;
      default:   o_rdata = 16'h0000;
    endcase
  end

  assign o_gpio = r_gpio;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit multicycle CPU bus.
// Serves instruction fetch from IMEM, data reads/writes to DMEM or the
// register bank, and lets a side loader fill IMEM at any time.
// Ports:
//   CK, RST  : clock and synchronous active-low reset
//   IA / ID  : instruction address in, instruction word out (combinational)
//   DA       : data address from CPU
//   DD       : bidirectional data bus, driven here only while RW=1
//   RW       : 1 = read / idle, 0 = write
//   LD_WE, LD_A, LD_D : loader write port into IMEM
//   GPIO_OUT : GPIO output register
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int          IAW       = 8,
  parameter int          DAW       = 8,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic           CK,
  input  logic           RST,
  input  logic [15:0]    IA,
  output logic [15:0]    ID,
  input  logic [15:0]    DA,
  inout  wire  [15:0]    DD,
  input  logic           RW,
  input  logic           LD_WE,
  input  logic [IAW-1:0] LD_A,
  input  logic [15:0]    LD_D,
  output logic [15:0]    GPIO_OUT
);

  logic [15:0] r_imem [2**IAW];
  logic [15:0] r_dmem [2**DAW];

  logic [16:0] w_da_ext;
  logic [16:0] w_base_ext;
  logic        w_mmio_hit;
  logic [15:0] w_ofs_full;
  logic [3:0]  w_ofs;
  logic [DAW-1:0] w_didx;
  logic        w_wr_acc;
  logic        w_mmio_we;
  logic        w_dmem_we;
  logic [15:0] w_mmio_rdata;
  logic [15:0] w_rdata;

  // Loader writes land on the edge; fetch sees the old word until then.
  always_ff @(posedge CK) begin
    if (LD_WE) begin
      r_imem[LD_A] <= LD_D;
    end
  end

  assign ID = r_imem[IA[IAW-1:0]];

  // 17-bit compare so a bank placed at the top of the map (base+16 = 2^16)
  // does not wrap the upper bound to zero.
  assign w_da_ext   = {1'b0, DA};
  assign w_base_ext = {1'b0, MMIO_BASE};
  assign w_mmio_hit = (w_da_ext >= w_base_ext) && (w_da_ext < (w_base_ext + 17'd16));
  assign w_ofs_full = DA - MMIO_BASE;
  assign w_ofs      = w_ofs_full[3:0];
  assign w_didx     = DA[DAW-1:0];

  assign w_wr_acc  = ~RW & RST;
  assign w_mmio_we = w_wr_acc & w_mmio_hit;
  assign w_dmem_we = w_wr_acc & ~w_mmio_hit;

  always_ff @(posedge CK) begin
    if (w_dmem_we) begin
      r_dmem[w_didx] <= DD;
    end
  end

  mmio_regs u_regs (
    .CK      (CK),
    .RST     (RST),
    .i_we    (w_mmio_we),
    .i_ofs   (w_ofs),
    .i_wdata (DD),
    .i_cnt   (w_wr_acc),
    .o_rdata (w_mmio_rdata),
    .o_gpio  (GPIO_OUT)
  );

  assign w_rdata = w_mmio_hit ? w_mmio_rdata : r_dmem[w_didx];

  // Output enable follows RW combinationally so the bus is released in the
  // same cycle the CPU starts driving it.
  assign DD = RW ? w_rdata : 16'hzzzz;

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  logic        CK;
  logic        RST;
  logic [15:0] IA;
  logic [15:0] ID;
  logic [15:0] DA;
  wire  [15:0] DD;
  logic        RW;
  logic        LD_WE;
  logic [7:0]  LD_A;
  logic [15:0] LD_D;
  logic [15:0] GPIO_OUT;

  logic [15:0] cpu_dd;

  // CPU model: drives the bus only while it is writing.
  assign DD = (!RW) ? cpu_dd : 16'hzzzz;

  cpu_mem_responder #(.IAW(8), .DAW(8), .MMIO_BASE(16'hFFF0)) dut (
    .CK       (CK),
    .RST      (RST),
    .IA       (IA),
    .ID       (ID),
    .DA       (DA),
    .DD       (DD),
    .RW       (RW),
    .LD_WE    (LD_WE),
    .LD_A     (LD_A),
    .LD_D     (LD_D),
    .GPIO_OUT (GPIO_OUT)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic        rw;
    logic [15:0] da;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_exp(input string name, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] act);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge CK);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    RST    = 1'b0;
    RW     = 1'b1;
    IA     = 16'h0000;
    DA     = 16'h0000;
    cpu_dd = 16'h0000;
    LD_WE  = 1'b1;
    LD_A   = 8'd7;
    LD_D   = 16'h7777;

    // Reset for two edges, loading IMEM[7] meanwhile.
    repeat (2) @(posedge CK);
    #1;
    RST   = 1'b1;
    LD_WE = 1'b0;
    repeat (10) @(posedge CK);
    #1;
    DA = 16'hFFF1;
    push_exp("cyc_after_reset", 16'd10);
    @(negedge CK);
    check(DD);
    DA = 16'hFFF0;
    #1;
    push_exp("gpio_read_reset", 16'h0000);
    check(DD);
    push_exp("gpio_out_reset", 16'h0000);
    check(GPIO_OUT);
    IA = 16'h0007;
    #1;
    push_exp("load_during_reset", 16'h7777);
    check(ID);
    next_cycle();

    // Loader then fetch, and same-edge overwrite.
    LD_WE = 1'b1; LD_A = 8'd5; LD_D = 16'h1234;
    next_cycle();
    LD_WE = 1'b0;
    IA = 16'h0005;
    push_exp("fetch_loaded", 16'h1234);
    @(negedge CK);
    check(ID);
    next_cycle();
    LD_WE = 1'b1; LD_A = 8'd5; LD_D = 16'hABCD;
    push_exp("fetch_before_overwrite", 16'h1234);
    @(negedge CK);
    check(ID);
    next_cycle();
    LD_WE = 1'b0;
    push_exp("fetch_after_overwrite", 16'hABCD);
    check(ID);
    IA = 16'h0105;
    #1;
    push_exp("fetch_alias", 16'hABCD);
    check(ID);

    // Data / register bank vectors. Write rows check the CPU value is clean
    // on DD (no contention); read rows check same-cycle read data.
    vecs.push_back('{1'b0, 16'h0010, 16'h5A5A, 16'h0000});
    vecs.push_back('{1'b1, 16'h0010, 16'h0000, 16'h5A5A});
    vecs.push_back('{1'b1, 16'hFFF2, 16'h0000, 16'h0001});
    vecs.push_back('{1'b1, 16'h0110, 16'h0000, 16'h5A5A});
    vecs.push_back('{1'b0, 16'hFFF0, 16'h00FF, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFF0, 16'h0000, 16'h00FF});
    vecs.push_back('{1'b0, 16'hFFF3, 16'h1234, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFF3, 16'h0000, 16'hC0DE});
    vecs.push_back('{1'b1, 16'hFFF2, 16'h0000, 16'h0003});
    vecs.push_back('{1'b0, 16'h0080, 16'hBEEF, 16'h0000});
    vecs.push_back('{1'b0, 16'hFFF2, 16'h0100, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFF2, 16'h0000, 16'h0100});
    vecs.push_back('{1'b0, 16'hFFF9, 16'h5555, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFF9, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFF2, 16'h0000, 16'h0101});
    vecs.push_back('{1'b1, 16'h0080, 16'h0000, 16'hBEEF});
    vecs.push_back('{1'b0, 16'hFFEF, 16'h0EEF, 16'h0000});
    vecs.push_back('{1'b1, 16'h00EF, 16'h0000, 16'h0EEF});
    vecs.push_back('{1'b0, 16'h00FF, 16'h1357, 16'h0000});
    vecs.push_back('{1'b0, 16'hFFFF, 16'h2468, 16'h0000});
    vecs.push_back('{1'b1, 16'h00FF, 16'h0000, 16'h1357});
    vecs.push_back('{1'b1, 16'hFFF2, 16'h0000, 16'h0104});
    vecs.push_back('{1'b1, 16'hFFF0, 16'h0000, 16'h00FF});

    for (int i = 0; i < vecs.size(); i++) begin
      RW     = vecs[i].rw;
      DA     = vecs[i].da;
      cpu_dd = vecs[i].wd;
      push_exp($sformatf("vec%0d_dd", i), vecs[i].rw ? vecs[i].exp_rd : vecs[i].wd);
      @(negedge CK);
      check(DD);
      next_cycle();
    end
    RW = 1'b1;
    push_exp("gpio_out_written", 16'h00FF);
    check(GPIO_OUT);

    // Cycle counter load then wrap.
    RW = 1'b0; DA = 16'hFFF1; cpu_dd = 16'hFFFE;
    next_cycle();
    RW = 1'b1;
    push_exp("cyc_loaded", 16'hFFFE);
    @(negedge CK);
    check(DD);
    next_cycle();
    push_exp("cyc_ffff", 16'hFFFF);
    check(DD);
    next_cycle();
    push_exp("cyc_wrap", 16'h0000);
    check(DD);

    // Preload DMEM[0x20], then a write coinciding with reset.
    RW = 1'b0; DA = 16'h0020; cpu_dd = 16'h1111;
    next_cycle();
    RST = 1'b0; cpu_dd = 16'h7777;
    push_exp("dd_during_reset_write", 16'h7777);
    @(negedge CK);
    check(DD);
    next_cycle();
    RST = 1'b1; RW = 1'b1; DA = 16'h0020;
    push_exp("dmem_unchanged_by_reset_write", 16'h1111);
    @(negedge CK);
    check(DD);
    DA = 16'hFFF2;
    #1;
    push_exp("wcnt_cleared", 16'h0000);
    check(DD);
    push_exp("gpio_cleared", 16'h0000);
    check(GPIO_OUT);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
